video_fetch: RTL and testbench

Video data fetcher that sits directly upstream of the renderer stage. Per scanline it reads 16-bit words from DRAM over a request/strobe handshake and double-buffers them. It presents a 32-bit pixel group plus the in-group pixel selector `psel` in the format the renderer consumes for ZX, 16c, 256c and text modes. While the front buffer is displayed, the back buffer is refilled, so the renderer never waits on DRAM.

---
 rtl/video_pkg.sv | 41 ++++
 rtl/video_fetch_buf.sv | 72 +++++++
 rtl/video_fetch.sv | 147 ++++++++++++++
 tb/tb_video_fetch.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared constants and group-geometry helpers for the video fetch path.
package video_pkg;

  localparam int unsigned DW = 16;  // DRAM word width
  localparam int unsigned GW = 32;  // pixel group width presented to the renderer

  typedef enum logic [1:0] {
    R_ZX = 2'd0,
    R_HC = 2'd1,
    R_XC = 2'd2,
    R_TX = 2'd3
  } render_mode_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFETCH = 2'd1,
    S_RUN      = 2'd2
  } fetch_state_e;

  // Index of the last pixel within one group for the given mode.
  function automatic logic [3:0] group_last(input logic [1:0] mode);
    logic [3:0] last;
    case (mode)
      R_ZX, R_TX: last = 4'd15;
      R_HC:       last = 4'd3;
      default:    last = 4'd1;
    endcase
    return last;
  endfunction

  // Number of DRAM words that make up one group for the given mode.
  function automatic logic [1:0] words_per_group(input logic [1:0] mode);
    logic [1:0] wpg;
    case (mode)
      R_ZX, R_TX: wpg = 2'd2;
      default:    wpg = 2'd1;
    endcase
    return wpg;
  endfunction

endpackage

// File: rtl/video_fetch_buf.sv
// Double buffer: back buffer collects DRAM words, front buffer drives the renderer.
module video_fetch_buf
  import video_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic [1:0]    wpg_i,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          swap_i,
  output logic [GW-1:0] data_o,
  output logic [1:0]    bcnt_o,
  output logic          full_c,
  output logic [1:0]    bcnt_nxt_c,
  output logic          wr_ok_c,
  output logic          swap_ok_c
);

  logic [DW-1:0] back0_q, back0_d;
  logic [DW-1:0] back1_q, back1_d;
  logic [DW-1:0] front0_q, front0_d;
  logic [DW-1:0] front1_q, front1_d;
  logic [1:0]    bcnt_q, bcnt_d;

  // Writes only land in a non-full back buffer; swaps only happen from a full one.
  assign full_c    = (bcnt_q == wpg_i);
  assign wr_ok_c   = wr_i && !full_c && !clr_i;
  assign swap_ok_c = swap_i && full_c && !clr_i;

  // Back-buffer fill, swap into front, and line-restart clear of the word count.
  always_comb begin
    back0_d  = back0_q;
    back1_d  = back1_q;
    front0_d = front0_q;
    front1_d = front1_q;
    bcnt_d   = bcnt_q;
    if (clr_i) begin
      bcnt_d = 2'd0;
    end else if (swap_ok_c) begin
      front0_d = back0_q;
      front1_d = (wpg_i == 2'd2) ? back1_q : '0;
      bcnt_d   = 2'd0;
    end else if (wr_ok_c) begin
      if (bcnt_q == 2'd0) back0_d = wdata_i;
      else                back1_d = wdata_i;
      bcnt_d = bcnt_q + 2'd1;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      back0_q  <= '0;
      back1_q  <= '0;
      front0_q <= '0;
      front1_q <= '0;
      bcnt_q   <= 2'd0;
    end else begin
      back0_q  <= back0_d;
      back1_q  <= back1_d;
      front0_q <= front0_d;
      front1_q <= front1_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign data_o     = {front1_q, front0_q};
  assign bcnt_o     = bcnt_q;
  assign bcnt_nxt_c = bcnt_d;

endmodule

// File: rtl/video_fetch.sv
// Per-scanline DRAM fetcher feeding pixel groups and pixel selector to the renderer.
module video_fetch
  import video_pkg::*;
#(
  parameter int unsigned AW = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_stb,
  input  logic          line_start,
  input  logic          fetch_en,
  input  logic [1:0]    render_mode,
  input  logic [AW-1:0] gfx_base,
  input  logic [AW-1:0] atr_base,
  output logic          vid_req,
  output logic [AW-1:0] vid_addr,
  input  logic          vid_strb,
  input  logic [DW-1:0] vid_data,
  output logic [GW-1:0] data,
  output logic [3:0]    psel,
  output logic          underrun
);

  fetch_state_e  state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] gfx_ptr_q, gfx_ptr_d;
  logic [AW-1:0] atr_ptr_q, atr_ptr_d;
  logic [AW-1:0] vid_addr_q, vid_addr_d;
  logic [3:0]    psel_q, psel_d;
  logic          front_vld_q, front_vld_d;
  logic          underrun_q, underrun_d;
  logic          vid_req_q, vid_req_d;

  logic [1:0]    wpg_cur, wpg_nxt;
  logic [3:0]    last_idx;
  logic          adv, wrap;
  logic          buf_wr, buf_swap;
  logic [1:0]    bcnt, bcnt_nxt;
  logic          full, wr_ok, swap_ok;

  assign wpg_cur  = words_per_group(mode_q);
  assign last_idx = group_last(mode_q);

  // A qualifying pixel strobe only counts in RUN; line_start pre-empts everything.
  assign adv      = pix_stb && fetch_en && (state_q == S_RUN) && !line_start;
  assign wrap     = adv && (psel_q == last_idx);
  assign buf_wr   = vid_strb && (state_q != S_IDLE) && !line_start;
  assign buf_swap = !line_start &&
                    (wrap || ((state_q == S_PREFETCH) && !front_vld_q));

  video_fetch_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (line_start),
    .wpg_i      (wpg_cur),
    .wr_i       (buf_wr),
    .wdata_i    (vid_data),
    .swap_i     (buf_swap),
    .data_o     (data),
    .bcnt_o     (bcnt),
    .full_c     (full),
    .bcnt_nxt_c (bcnt_nxt),
    .wr_ok_c    (wr_ok),
    .swap_ok_c  (swap_ok)
  );

  // Next-state: line control, pointer advance, pixel selector and request outputs.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    gfx_ptr_d   = gfx_ptr_q;
    atr_ptr_d   = atr_ptr_q;
    psel_d      = psel_q;
    front_vld_d = front_vld_q;
    underrun_d  = underrun_q;

    unique case (state_q)
      S_IDLE: ;
      S_PREFETCH: begin
        if (swap_ok) front_vld_d = 1'b1;
        if (front_vld_q && full) state_d = S_RUN;
      end
      S_RUN: begin
        if (adv) begin
          if (wrap) begin
            psel_d = 4'd0;
            if (!full) underrun_d = 1'b1;
          end else begin
            psel_d = psel_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // ZX/text groups fetch gfx into slot 0 and attr into slot 1.
    if (wr_ok) begin
      if ((wpg_cur == 2'd2) && (bcnt == 2'd1)) atr_ptr_d = atr_ptr_q + AW'(1);
      else                                    gfx_ptr_d = gfx_ptr_q + AW'(1);
    end

    if (line_start) begin
      state_d     = S_PREFETCH;
      mode_d      = render_mode;
      gfx_ptr_d   = gfx_base;
      atr_ptr_d   = atr_base;
      psel_d      = 4'd0;
      front_vld_d = 1'b0;
      underrun_d  = underrun_q;
    end

    wpg_nxt    = words_per_group(mode_d);
    vid_addr_d = ((wpg_nxt == 2'd2) && (bcnt_nxt == 2'd1)) ? atr_ptr_d : gfx_ptr_d;
    vid_req_d  = (state_d != S_IDLE) && (bcnt_nxt != wpg_nxt);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      gfx_ptr_q   <= '0;
      atr_ptr_q   <= '0;
      vid_addr_q  <= '0;
      psel_q      <= 4'd0;
      front_vld_q <= 1'b0;
      underrun_q  <= 1'b0;
      vid_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      gfx_ptr_q   <= gfx_ptr_d;
      atr_ptr_q   <= atr_ptr_d;
      vid_addr_q  <= vid_addr_d;
      psel_q      <= psel_d;
      front_vld_q <= front_vld_d;
      underrun_q  <= underrun_d;
      vid_req_q   <= vid_req_d;
    end
  end

  assign vid_req  = vid_req_q;
  assign vid_addr = vid_addr_q;
  assign psel     = psel_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_video_fetch.sv
// Bench for video_fetch: random DRAM responder and a word-count reference model.
module tb_video_fetch;

  localparam int unsigned AW = 21;

  logic          clk;
  logic          rst;
  logic          pix_stb;
  logic          line_start;
  logic          fetch_en;
  logic [1:0]    render_mode;
  logic [AW-1:0] gfx_base;
  logic [AW-1:0] atr_base;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_strb;
  logic [15:0]   vid_data;
  logic [31:0]   data;
  logic [3:0]    psel;
  logic          underrun;

  video_fetch #(.AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_stb     (pix_stb),
    .line_start  (line_start),
    .fetch_en    (fetch_en),
    .render_mode (render_mode),
    .gfx_base    (gfx_base),
    .atr_base    (atr_base),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_strb    (vid_strb),
    .vid_data    (vid_data),
    .data        (data),
    .psel        (psel),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // DRAM contents: a hash of the address unless a test pins a specific word.
  logic [15:0] mem_ovr [logic [AW-1:0]];

  function automatic logic [15:0] word_at(input logic [AW-1:0] a);
    logic [31:0] t;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    t = 32'(a) * 32'd40503;
    return t[15:0] ^ 16'(a >> 7);
  endfunction

  // Reference model: line parameters plus word/group counters.
  bit            m_active, m_fvalid, m_run, m_und;
  int            m_mode, m_nstrb, m_cons, m_fg, m_psel;
  logic [AW-1:0] m_g, m_a;
  logic [31:0]   m_data;

  // Stimulus knobs.
  int            cur_mode;
  logic [AW-1:0] cur_g, cur_a;
  bit            strb_en;
  int            strb_pct;

  function automatic int m_wpg();
    return (m_mode == 0 || m_mode == 3) ? 2 : 1;
  endfunction

  function automatic int m_last();
    return (m_mode == 0 || m_mode == 3) ? 15 : (m_mode == 1) ? 3 : 1;
  endfunction

  // Address of the i-th word requested in the current line.
  function automatic logic [AW-1:0] req_addr(input int i);
    if (m_wpg() == 2) return (i % 2 == 1) ? m_a + AW'(i / 2) : m_g + AW'(i / 2);
    return m_g + AW'(i);
  endfunction

  function automatic logic [31:0] grp(input int g);
    if (m_wpg() == 2) return {word_at(m_a + AW'(g)), word_at(m_g + AW'(g))};
    return {16'h0000, word_at(m_g + AW'(g))};
  endfunction

  function automatic bit exp_req();
    return m_active && ((m_nstrb - m_cons) < m_wpg());
  endfunction

  function automatic logic [AW-1:0] exp_addr();
    return m_active ? req_addr(m_nstrb) : '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("data", data, m_data);
    chk("psel", 32'(psel), 32'(m_psel));
    chk("vid_req", 32'(vid_req), 32'(exp_req()));
    chk("vid_addr", 32'(vid_addr), 32'(exp_addr()));
    chk("underrun", 32'(underrun), 32'(m_und));
  endtask

  // One clock: check outputs, drive inputs for the coming edge, advance the model.
  task automatic step(input bit r, input bit ls, input bit ps, input bit fe, input bit frc);
    bit s;
    bit full;
    @(negedge clk);
    check_all();
    s = 1'b0;
    if (exp_req() && (frc || (strb_en && ($urandom_range(0, 99) < strb_pct)))) s = 1'b1;
    rst        = r;
    line_start = ls;
    pix_stb    = ps;
    fetch_en   = fe;
    vid_strb   = s;
    vid_data   = s ? word_at(exp_addr()) : 16'($urandom);
    if (ls) begin
      render_mode = 2'(cur_mode);
      gfx_base    = cur_g;
      atr_base    = cur_a;
    end else begin
      render_mode = 2'($urandom);
      gfx_base    = AW'($urandom);
      atr_base    = AW'($urandom);
    end

    if (r) begin
      m_active = 0; m_fvalid = 0; m_run = 0; m_und = 0;
      m_data = '0; m_psel = 0; m_nstrb = 0; m_cons = 0; m_fg = -1;
    end else if (ls) begin
      m_active = 1; m_fvalid = 0; m_run = 0;
      m_mode = cur_mode; m_g = cur_g; m_a = cur_a;
      m_nstrb = 0; m_cons = 0; m_fg = -1; m_psel = 0;
    end else if (m_active) begin
      full = ((m_nstrb - m_cons) == m_wpg());
      if (!m_run) begin
        if (full && !m_fvalid) begin
          m_fvalid = 1; m_fg = 0; m_cons += m_wpg(); m_data = grp(0);
        end else if (full) begin
          m_run = 1;
        end
        if (s) m_nstrb++;
      end else begin
        if (s) m_nstrb++;
        if (ps && fe) begin
          if (m_psel == m_last()) begin
            m_psel = 0;
            if (full) begin
              m_fg++; m_cons += m_wpg(); m_data = grp(m_fg);
            end else begin
              m_und = 1;
            end
          end else begin
            m_psel++;
          end
        end
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic start_line(input int mode, input logic [AW-1:0] g, input logic [AW-1:0] a);
    cur_mode = mode; cur_g = g; cur_a = a;
    step(0, 1, 0, 0, 0);
  endtask

  // Run until the model reaches RUN; stray pixel strobes must be ignored meanwhile.
  task automatic wait_run(input int budget);
    for (int i = 0; i < budget && !m_run; i++) step(0, 0, 1'($urandom), 1, 0);
    n_cmp++;
    assert (m_run) else begin
      n_bad++;
      $error("FAIL wait_run: observed timeout expected RUN within %0d cycles", budget);
    end
  endtask

  task automatic run_pix(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, gap)) step(0, 0, 1'($urandom), 0, 0);
      step(0, 0, 1, 1, 0);
    end
  endtask

  initial begin
    rst = 1'b1; line_start = 1'b0; pix_stb = 1'b0; fetch_en = 1'b0;
    render_mode = 2'd0; gfx_base = '0; atr_base = '0;
    vid_strb = 1'b0; vid_data = '0;
    m_active = 0; m_fvalid = 0; m_run = 0; m_und = 0;
    m_mode = 0; m_nstrb = 0; m_cons = 0; m_fg = -1; m_psel = 0;
    m_g = '0; m_a = '0; m_data = '0;
    cur_mode = 0; cur_g = '0; cur_a = '0;
    strb_en = 1; strb_pct = 100;

    // Reset state.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle();
    chk("reset_req", 32'(vid_req), 32'd0);
    chk("reset_data", data, 32'd0);

    // ZX line with slow-ish DRAM answers.
    strb_pct = 50;
    start_line(0, AW'(21'h100), AW'(21'h1800));
    idle();
    chk("zx_addr0", 32'(vid_addr), 32'h100);
    wait_run(200);
    chk("zx_g0", data, {word_at(AW'(21'h1800)), word_at(AW'(21'h100))});
    run_pix(16, 1);
    idle();
    chk("zx_g1", data, {word_at(AW'(21'h1801)), word_at(AW'(21'h101))});
    run_pix(24, 1);

    // 256c with pinned words.
    mem_ovr[AW'(21'h2000)] = 16'hA1B2;
    mem_ovr[AW'(21'h2001)] = 16'hC3D4;
    strb_pct = 100;
    start_line(2, AW'(21'h2000), AW'(21'h0));
    wait_run(50);
    idle();
    chk("256c_g0", data, 32'h0000A1B2);
    run_pix(1, 0);
    idle();
    chk("256c_psel1", 32'(psel), 32'd1);
    run_pix(1, 0);
    idle();
    chk("256c_g1", data, 32'h0000C3D4);
    chk("256c_psel0", 32'(psel), 32'd0);

    // 16c underrun: no strobes after prefetch.
    start_line(1, AW'(21'h3000), AW'(21'h0));
    wait_run(50);
    strb_en = 0;
    run_pix(8, 0);
    idle();
    chk("und_flag", 32'(underrun), 32'd1);
    chk("und_repeat", data, {16'h0000, word_at(AW'(21'h3001))});
    strb_en = 1;
    start_line(1, AW'(21'h3100), AW'(21'h0));
    wait_run(50);
    chk("und_sticky", 32'(underrun), 32'd1);

    // Restart mid-line coincident with strobe and pixel strobe.
    start_line(0, AW'(21'h500), AW'(21'h900));
    wait_run(50);
    strb_en = 0;
    run_pix(16, 0);
    cur_mode = 2; cur_g = AW'(21'h4444); cur_a = AW'(21'h0);
    step(0, 1, 1, 1, 1);
    idle();
    chk("rst_line_psel", 32'(psel), 32'd0);
    chk("rst_line_addr", 32'(vid_addr), 32'h4444);
    strb_en = 1;
    wait_run(50);
    chk("rst_line_data", data, {16'h0000, word_at(AW'(21'h4444))});

    // Pointer wrap in 16c mode.
    strb_en = 0;
    start_line(1, AW'(21'h1FFFFF), AW'(21'h0));
    idle();
    chk("wrap_addr0", 32'(vid_addr), 32'h1FFFFF);
    step(0, 0, 0, 0, 1);
    idle();
    chk("wrap_addr1", 32'(vid_addr), 32'h0);
    strb_en = 1;

    // Random lines across all modes.
    for (int ln = 0; ln < 6; ln++) begin
      strb_pct = $urandom_range(40, 100);
      start_line($urandom_range(0, 3), AW'($urandom), AW'($urandom));
      wait_run(400);
      run_pix($urandom_range(10, 40), 3);
    end

    // Reset in the middle of a text line.
    strb_pct = 100;
    start_line(3, AW'(21'h7000), AW'(21'h7800));
    wait_run(50);
    run_pix(5, 0);
    step(1, 0, 1, 1, 0);
    idle();
    chk("mrst_req", 32'(vid_req), 32'd0);
    chk("mrst_data", data, 32'd0);
    chk("mrst_psel", 32'(psel), 32'd0);
    chk("mrst_und", 32'(underrun), 32'd0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
